// File: rtl/cla_share_arbiter_pkg.sv
// Shared constants and types for the CLA share arbiter: datapath defaults,
// adder block size and the per-stage tag carried alongside each operation.
package cla_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int LATENCY_DEF = 2;
    localparam int CLA_BLK     = 4;

    // Tags are sized for the largest supported lane count (16); the top
    // zero-extends its $clog2(NUM_REQ)-bit lane id into this field.
    localparam int MAX_REQ  = 16;
    localparam int TAG_ID_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/cla_share_arbiter_if.sv
// Bundle between the MAC lanes, the shared CLA and the arbiter.
// slave = arbiter view, master = lanes plus adder view.
interface cla_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic                      en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_sub;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic                      add_cin;
    logic [DATA_W-1:0]         add_sum;
    logic                      add_cout;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_cout;
    logic                      busy;

    modport slave (
        input  en, req_valid, req_a, req_b, req_sub, add_sum, add_cout,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, busy
    );

    modport master (
        output en, req_valid, req_a, req_b, req_sub, add_sum, add_cout,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above i_ptr,
// wrapping around, reported as a one-hot grant plus its binary id.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);
    int w_idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        // Walk from the farthest candidate to the nearest so the lane
        // closest to the pointer is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_id           = ID_W'(w_idx);
                o_any          = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cla_share_arbiter.sv
// Time-shares one pipelined CLA add/sub unit among NUM_REQ MAC lanes and
// routes each result back to its lane after the adder latency.
module cla_share_arbiter
    import cla_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_share_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_id;
    logic               w_any;
    logic               w_issue_en;
    logic               w_xfer;
    logic               w_busy;
    tag_t               w_last;
    logic [ID_W-1:0]    r_rr_ptr;
    tag_t               r_tag [LATENCY];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    // Holding ready low while rst_n is asserted keeps lanes from seeing an
    // accept that the cleared pipe would never answer.
    assign w_issue_en    = bus.en & rst_n;
    assign w_xfer        = w_any & w_issue_en;
    assign bus.req_ready = w_grant & {NUM_REQ{w_issue_en}};

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (w_xfer) begin
            bus.add_a   = bus.req_a[w_id*DATA_W +: DATA_W];
            bus.add_b   = bus.req_b[w_id*DATA_W +: DATA_W];
            bus.add_cin = bus.req_sub[w_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag array is reset (it is tiny and its valids gate
            // every response); the adder's data pipe is deliberately not.
            for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= '{valid: w_xfer, id: TAG_ID_W'(w_id)};
            for (int s = 1; s < LATENCY; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    assign w_last = r_tag[LATENCY-1];

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) w_busy = w_busy | r_tag[s].valid;
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = w_last.valid && (w_last.id == TAG_ID_W'(i));
        end
    end

    assign bus.busy     = w_busy;
    assign bus.rsp_sum  = bus.add_sum;
    assign bus.rsp_cout = bus.add_cout;

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed plus randomized bench for cla_share_arbiter with a two-stage
// behavioural CLA add/sub unit closing the loop on the add_* ports.
module tb_cla_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 2;

    logic clk;
    logic rst_n;

    cla_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    cla_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-side stimulus, packed onto the interface.
    logic [NUM_REQ-1:0] lane_valid;
    logic [DATA_W-1:0]  lane_a   [NUM_REQ];
    logic [DATA_W-1:0]  lane_b   [NUM_REQ];
    logic [NUM_REQ-1:0] lane_sub;

    always_comb begin
        bus.req_valid = lane_valid;
        bus.req_sub   = lane_sub;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*DATA_W +: DATA_W] = lane_a[i];
            bus.req_b[i*DATA_W +: DATA_W] = lane_b[i];
        end
    end

    // Behavioural CLA: B is inverted and Cin added when subtracting; cout is
    // the raw carry out, so for A-B it reads 1 when no borrow occurred.
    logic [DATA_W-1:0] add_a_q, add_b_q;
    logic              add_cin_q;
    logic [DATA_W:0]   add_full;

    assign add_full = {1'b0, add_a_q} + {1'b0, add_b_q ^ {DATA_W{add_cin_q}}} + (DATA_W+1)'(add_cin_q);

    always_ff @(posedge clk) begin
        add_a_q      <= bus.add_a;
        add_b_q      <= bus.add_b;
        add_cin_q    <= bus.add_cin;
        bus.add_sum  <= add_full[DATA_W-1:0];
        bus.add_cout <= add_full[DATA_W];
    end

    // Reference model: pointer, pending responses with the cycle they are due.
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] sum;
        logic              cout;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr;
    int   m_grant;
    int   m_last_xfer;
    int   cyc;
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Mid-cycle: compare every DUT output against the model.
    task automatic half();
        logic [NUM_REQ-1:0] e_ready;
        logic [NUM_REQ-1:0] e_rsp;
        logic [DATA_W-1:0]  e_a, e_b;
        logic               e_cin;
        @(negedge clk);
        m_grant = -1;
        if (rst_n && bus.en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_grant < 0 && lane_valid[(m_ptr + k) % NUM_REQ]) m_grant = (m_ptr + k) % NUM_REQ;
            end
        end
        e_ready = '0;
        e_a     = '0;
        e_b     = '0;
        e_cin   = 1'b0;
        if (m_grant >= 0) begin
            e_ready[m_grant] = 1'b1;
            e_a              = lane_a[m_grant];
            e_b              = lane_b[m_grant];
            e_cin            = lane_sub[m_grant];
        end
        check("req_ready", 64'(bus.req_ready), 64'(e_ready));
        check("add_a", 64'(bus.add_a), 64'(e_a));
        check("add_b", 64'(bus.add_b), 64'(e_b));
        check("add_cin", 64'(bus.add_cin), 64'(e_cin));
        check("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
        e_rsp = '0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e_rsp[exp_q[0].id] = 1'b1;
            check("rsp_sum", 64'(bus.rsp_sum), 64'(exp_q[0].sum));
            check("rsp_cout", 64'(bus.rsp_cout), 64'(exp_q[0].cout));
            void'(exp_q.pop_front());
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
    endtask

    // Clock edge: advance the model, then leave 1 time unit for new stimulus.
    task automatic edge_step();
        exp_t e;
        @(posedge clk);
        m_last_xfer = -1;
        if (m_grant >= 0 && rst_n) begin
            e.due  = cyc + 2;
            e.id   = m_grant;
            e.sum  = lane_sub[m_grant] ? lane_a[m_grant] - lane_b[m_grant]
                                       : lane_a[m_grant] + lane_b[m_grant];
            e.cout = lane_sub[m_grant] ? (lane_a[m_grant] >= lane_b[m_grant])
                                       : ((int'(lane_a[m_grant]) + int'(lane_b[m_grant])) > 65535);
            exp_q.push_back(e);
            m_ptr       = (m_grant + 1) % NUM_REQ;
            m_last_xfer = m_grant;
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        half();
        edge_step();
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_ptr = 0;
    endtask

    task automatic do_reset();
        enter_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // One isolated op on one lane, checked against constants.
    task automatic single_op(input int lane, input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic [15:0] exp_sum, input logic exp_cout,
                             input string tag);
        lane_valid       = '0;
        lane_valid[lane] = 1'b1;
        lane_a[lane]     = a;
        lane_b[lane]     = b;
        lane_sub[lane]   = sub;
        half();
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(4'b0001 << lane));
        edge_step();
        lane_valid = '0;
        cycle();
        half();
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(4'b0001 << lane));
        check({tag, "_sum"}, 64'(bus.rsp_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.rsp_cout), 64'(exp_cout));
        edge_step();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        m_ptr       = 0;
        m_grant     = -1;
        m_last_xfer = -1;
        bus.en      = 1'b1;
        lane_sub    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_a[i] = 16'(i * 16'h0101);
            lane_b[i] = 16'(i + 1);
        end

        // 1: reset with every lane requesting
        lane_valid = 4'b1111;
        enter_reset();
        #1;
        half();
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        edge_step();
        lane_valid = '0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // 2: single add on lane 2
        single_op(2, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, "add_l2");
        // 3: subtracts on lane 0, both borrow directions, plus add overflow
        single_op(0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        single_op(0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
        single_op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_ovf");
        cycle();

        // 4: round robin from a fresh pointer, all lanes valid for 8 cycles
        do_reset();
        lane_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            half();
            check("rr_order", 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
            edge_step();
        end

        // 5: wrap to lane 1, then en low holds the pointer at 2
        lane_valid = 4'b0010;
        half();
        check("wrap_l1", 64'(bus.req_ready), 64'h2);
        edge_step();
        lane_valid = 4'b1111;
        bus.en     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half();
            check("en_off_ready", 64'(bus.req_ready), 64'h0);
            edge_step();
        end
        bus.en = 1'b1;
        half();
        check("ptr_held", 64'(bus.req_ready), 64'h4);
        edge_step();
        lane_valid = '0;
        for (int i = 0; i < 3; i++) cycle();
        check("drained_busy", 64'(bus.busy), 64'h0);

        // 6: reset the cycle after issuing lane 1; its result must vanish
        lane_valid = 4'b0010;
        cycle();
        lane_valid = '0;
        enter_reset();
        half();
        check("midrst_busy", 64'(bus.busy), 64'h0);
        check("midrst_rsp", 64'(bus.rsp_valid), 64'h0);
        edge_step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            half();
            check("postrst_rsp", 64'(bus.rsp_valid), 64'h0);
            edge_step();
        end

        // Randomized traffic: lanes hold until accepted, en toggles occasionally.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == m_last_xfer || !lane_valid[i]) begin
                    lane_valid[i] = ($urandom_range(0, 99) < 60);
                    lane_sub[i]   = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 5))
                        0:       lane_a[i] = 16'hFFFF;
                        1:       lane_a[i] = 16'h0000;
                        default: lane_a[i] = 16'($urandom);
                    endcase
                    case ($urandom_range(0, 5))
                        0:       lane_b[i] = 16'hFFFF;
                        1:       lane_b[i] = lane_a[i];
                        default: lane_b[i] = 16'($urandom);
                    endcase
                end
            end
            bus.en = ($urandom_range(0, 7) != 0);
            cycle();
        end
        lane_valid = '0;
        bus.en     = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("final_busy", 64'(bus.busy), 64'h0);
        check("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
